// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sequencer between a core and a single-port
// memory with an ack handshake.
//
// Each accepted request makes one memory access. The unit forms the byte
// lane enables, replicates store data across lanes, and extracts and
// extends load data. It also flags three errors: misaligned address,
// illegal funct3, and ack timeout.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   req        core requests a load/store this cycle
//   mem_rw     0 = load, 1 = store
//   funct3     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr       byte address
//   st_data    store data
//   mem_req    memory request, held through ACCESS
//   mem_we     memory write enable
//   mem_addr   word-aligned address
//   mem_be     byte-lane enables
//   mem_wdata  lane-replicated store data
//   mem_ack    memory completion, mem_rdata valid in the same cycle
//   mem_rdata  memory read word
//   ld_data    extracted/extended load result, held until the next load
//   data_vld   one-cycle completion pulse
//   busy       high in ACCESS and RESP
//   err        one-cycle exception pulse
//   err_code   01 misaligned, 10 illegal funct3, 11 timeout (valid with err)
//
// state  | meaning
// IDLE   | waiting for req; errors on bad requests are reported from here
// ACCESS | mem_req asserted, waiting for mem_ack or timeout
// RESP   | data_vld pulse, then back to IDLE

module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        mem_rw,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ld_data,
   output logic        data_vld,
   output logic        busy,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Counter value seen during the final permitted ACCESS cycle.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        rw_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] st_q;
   logic [7:0]  wait_cnt;

   logic        illegal;
   logic        misaligned;
   logic        accept;
   logic        in_access;
   logic        ack_hit;
   logic        timeout_hit;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] ld_c;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Request decode. Stores have no unsigned variants, so only B/H/W pass.
   always_comb begin
      illegal = 1'b0;
      if (mem_rw)
         illegal = (funct3 > 3'b010);
      else
         illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
   end

   always_comb begin
      misaligned = 1'b0;
      case (funct3)
         3'b001, 3'b101: misaligned = addr[0];
         3'b010:         misaligned = (addr[1:0] != 2'b00);
         default:        misaligned = 1'b0;
      endcase
   end

   assign accept      = (state == IDLE) && req && !illegal && !misaligned;
   assign in_access   = (state == ACCESS);
   assign ack_hit     = in_access && mem_ack;
   // An ack in the last permitted cycle wins over the timeout.
   assign timeout_hit = in_access && !mem_ack && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = ACCESS;
         end
         ACCESS: begin
            if (mem_ack)
               state_nxt = RESP;
            else if (timeout_hit)
               state_nxt = IDLE;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw_q   <= 1'b0;
         f3_q   <= 3'b000;
         addr_q <= '0;
         st_q   <= '0;
      end else if (accept) begin
         rw_q   <= mem_rw;
         f3_q   <= funct3;
         addr_q <= addr;
         st_q   <= st_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= 8'd0;
      else if (accept)
         wait_cnt <= 8'd0;
      else if (in_access && !mem_ack)
         wait_cnt <= wait_cnt + 8'd1;
   end

   // Illegal takes priority over misaligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err      <= 1'b0;
         err_code <= 2'b00;
      end else begin
         err      <= 1'b0;
         err_code <= 2'b00;
         if ((state == IDLE) && req && illegal) begin
            err      <= 1'b1;
            err_code <= 2'b10;
         end else if ((state == IDLE) && req && misaligned) begin
            err      <= 1'b1;
            err_code <= 2'b01;
         end else if (timeout_hit) begin
            err      <= 1'b1;
            err_code <= 2'b11;
         end
      end
   end

   // Lane selection for the latched access; f3_q[1:0] is the size.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = st_q;
      case (f3_q[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr_q[1:0];
            wdata_c = {4{st_q[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << {addr_q[1], 1'b0};
            wdata_c = {2{st_q[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = st_q;
         end
      endcase
   end

   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (addr_q[1:0])
         2'b00:   ld_byte = mem_rdata[7:0];
         2'b01:   ld_byte = mem_rdata[15:8];
         2'b10:   ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_c    = mem_rdata;
      // f3_q[2] marks the unsigned variants.
      case (f3_q[1:0])
         2'b00:   ld_c = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
         2'b01:   ld_c = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
         default: ld_c = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ld_data <= '0;
      else if (ack_hit && !rw_q)
         ld_data <= ld_c;
   end

   // Memory-side outputs come straight from state, so reset removes
   // them without waiting for a clock edge.
   assign mem_req   = in_access;
   assign mem_we    = in_access && rw_q;
   assign mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be    = in_access ? be_c : 4'b0000;
   assign mem_wdata = in_access ? wdata_c : 32'd0;
   assign data_vld  = (state == RESP);
   assign busy      = (state != IDLE);

endmodule
